// File: rtl/ibex_register_file_mp.sv
// Flop-based register file: N read ports and 1-2 write ports; reads are combinational (0 cycles), writes land on the next clk_i edge.
// No backpressure; optional same-cycle forwarding, dummy R0 storage and a sticky write-enable error flag.
module ibex_register_file_mp #(
   parameter bit                   RV32E             = 1'b0,
   parameter int unsigned          DataWidth         = 32,
   parameter int unsigned          NumReadPorts      = 2,
   parameter int unsigned          NumWritePorts     = 1,
   parameter bit                   WriteForward      = 1'b0,
   parameter bit                   DummyInstructions = 1'b0,
   parameter bit                   WrenCheck         = 1'b0,
   parameter logic [DataWidth-1:0] WordResetVal      = '0,
   parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              dummy_instr_id_i,
   input  logic [NumReadPorts*5-1:0]         raddr_i,
   output logic [NumReadPorts*DataWidth-1:0] rdata_o,
   input  logic [NumWritePorts*5-1:0]        waddr_i,
   input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
   input  logic [NumWritePorts-1:0]          we_i,
   output logic                              err_o
);

   localparam int unsigned NUM_WORDS  = RV32E ? 16 : 32;
   localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;

   logic [NUM_WORDS-1:0][DataWidth-1:0]     rf_q, rf_d;
   logic [NumWritePorts-1:0][NUM_WORDS-1:0]  we_dec;
   logic [NumWritePorts-1:0][ADDR_WIDTH-1:0] waddr_t;
   logic [NumReadPorts-1:0][ADDR_WIDTH-1:0]  raddr_t;
   logic [NumReadPorts-1:0][DataWidth-1:0]   rdata_t;
   logic                                     dummy_en;
   logic                                     err_cyc;
   logic                                     err_d, err_q;
   logic                                     unused_in;

   assign dummy_en = DummyInstructions && dummy_instr_id_i;

   // Address truncation drops bit 4 in RV32E; writes below go through the one-hot decode.
   always_comb begin
      waddr_t = '0;
      raddr_t = '0;
      we_dec  = '0;
      for (int w = 0; w < NumWritePorts; w++) begin
         waddr_t[w] = waddr_i[5*w +: ADDR_WIDTH];
         for (int i = 0; i < NUM_WORDS; i++) begin
            we_dec[w][i] = we_i[w] && (waddr_t[w] == ADDR_WIDTH'(i));
         end
      end
      for (int p = 0; p < NumReadPorts; p++) begin
         raddr_t[p] = raddr_i[5*p +: ADDR_WIDTH];
      end
   end

   // Ascending port order lets port 1 override port 0 on an address collision.
   always_comb begin
      rf_d = rf_q;
      for (int w = 0; w < NumWritePorts; w++) begin
         for (int i = 1; i < NUM_WORDS; i++) begin
            if (we_dec[w][i]) rf_d[i] = wdata_i[DataWidth*w +: DataWidth];
         end
         if (dummy_en && we_dec[w][0]) rf_d[0] = wdata_i[DataWidth*w +: DataWidth];
      end
   end

   always_comb begin
      err_cyc = 1'b0;
      for (int w = 0; w < NumWritePorts; w++) begin
         if (RV32E && we_i[w] && waddr_i[5*w+4]) err_cyc = 1'b1;
         if (we_i[w]) begin
            if (($countones(we_dec[w]) != 1) || !we_dec[w][waddr_t[w]]) err_cyc = 1'b1;
         end else if (|we_dec[w]) begin
            err_cyc = 1'b1;
         end
      end
      err_d = err_q | (WrenCheck && err_cyc);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_q  <= {NUM_WORDS{WordResetVal}};
         err_q <= 1'b0;
      end else begin
         rf_q  <= rf_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      rdata_t = '0;
      for (int p = 0; p < NumReadPorts; p++) begin
         if (raddr_t[p] == '0) begin
            rdata_t[p] = dummy_en ? rf_q[0] : WordZeroVal;
         end else begin
            rdata_t[p] = rf_q[raddr_t[p]];
         end
         if (WriteForward) begin
            for (int w = 0; w < NumWritePorts; w++) begin
               if (we_i[w] && (waddr_t[w] == raddr_t[p]) && ((raddr_t[p] != '0) || dummy_en)) begin
                  rdata_t[p] = wdata_i[DataWidth*w +: DataWidth];
               end
            end
         end
      end
   end

   assign rdata_o   = rdata_t;
   assign err_o     = WrenCheck ? err_q : 1'b0;
   assign unused_in = ^{dummy_instr_id_i, waddr_i, raddr_i};

endmodule

// File: doc/ibex_register_file_mp.md
IBEX_REGISTER_FILE_MP -- requirements
Module: ibex_register_file_mp

Interface
REQ-001 Parameter RV32E, default 0: selects 16 architectural registers when 1, otherwise 32.
REQ-002 Parameter DataWidth, default 32: sets the register word width.
REQ-003 Parameter NumReadPorts, default 2, legal range 1..4: sets the number of independent read ports.
REQ-004 Parameter NumWritePorts, default 1, legal range 1..2: sets the number of write ports.
REQ-005 Parameter WriteForward, default 0: when 1, a read returns the same-cycle write data.
REQ-006 Parameter DummyInstructions, default 0: when 1, R0 is backed by real storage for dummy instructions.
REQ-007 Parameter WrenCheck, default 0: when 1, write-enable error detection is enabled.
REQ-008 Parameter WordResetVal, default '0: reset value of every stored word.
REQ-009 Parameter WordZeroVal, default '0: value R0 returns to non-dummy reads.
REQ-010 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-011 Port clk_i, input, 1 bit: the clock.
REQ-012 Port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-013 Port dummy_instr_id_i, input, 1 bit: marks the current access as a dummy instruction.
REQ-014 Port raddr_i, input, NumReadPorts*5 bits: read addresses; port p uses bits [5p+4:5p].
REQ-015 Port rdata_o, output, NumReadPorts*DataWidth bits: read data; slice p belongs to port p.
REQ-016 Port waddr_i, input, NumWritePorts*5 bits: write addresses, one 5-bit slice per port.
REQ-017 Port wdata_i, input, NumWritePorts*DataWidth bits: write data, one slice per port.
REQ-018 Port we_i, input, NumWritePorts bits: per-port write enable.
REQ-019 Port err_o, output, 1 bit: sticky write-enable error flag.

Function
REQ-020 Storage: flip-flop based, one register per address 1..NUM_WORDS-1, where NUM_WORDS = 16 if RV32E else 32.
REQ-021 Write timing: a write of wdata_i[w] to waddr_i[w] with we_i[w]=1 takes effect on the rising clk_i edge, so the data is visible to reads in the next cycle.
REQ-022 Write collision: if both write ports are enabled to the same address in one cycle, port 1's data is stored and port 0's write is discarded.
REQ-023 Read path: combinational; rdata_o[p] = mem[raddr_i[p][ADDR_WIDTH-1:0]]; reads are zero-latency.
REQ-024 Forwarding (WriteForward=1): if any enabled write port's address equals a read address and that address is nonzero, the read returns that write data in the same cycle; on a collision, port 1 takes priority.
REQ-025 Forwarding never applies to address 0 unless DummyInstructions=1 and dummy_instr_id_i=1.
REQ-026 Forwarding disabled (WriteForward=0): a read in the same cycle as a write to that address returns the old value.
REQ-027 R0 reads: R0 reads return WordZeroVal, and writes to address 0 are ignored, except under REQ-028.
REQ-028 Dummy R0 (DummyInstructions=1): an R0 storage register is written by any we_i[w] with waddr 0 while dummy_instr_id_i=1; R0 reads return that stored value while dummy_instr_id_i=1, and WordZeroVal otherwise.
REQ-029 RV32E address truncation: waddr_i and raddr_i use the lower 4 bits only.
REQ-030 RV32E error condition (WrenCheck=1): any we_i[w]=1 with waddr_i[w][4]=1 is an error.
REQ-031 Decoded-enable error (WrenCheck=1): the decoded one-hot write vector of each port is checked for exactly one bit set when enabled and none set when disabled; a mismatch with the address or enable is an error.
REQ-032 Error registration: err_o is set on the clock edge following any error cycle and stays 1 until reset.
REQ-033 Error and write interaction: a write that raises an error is still performed on the truncated address.
REQ-034 WrenCheck=0: err_o is tied to 0.
REQ-035 Unused input bits (dummy_instr_id_i when DummyInstructions=0; waddr_i[4] when RV32E=1 and WrenCheck=0) are explicitly sunk and have no functional effect.

Reset
REQ-036 While rst_ni=0, every stored register (R1..R(N-1), plus dummy R0 when present) holds WordResetVal and err_o=0, asynchronously.
REQ-037 Reads during reset return WordResetVal for R1 and above, and WordZeroVal for R0.
REQ-038 Writes presented during reset or in the deassertion cycle's edge are discarded; the first write takes effect on the first rising edge with rst_ni=1.

Verification
REQ-039 Defaults: write 0xDEADBEEF to x5, then read x5 on both ports the next cycle -> both ports return 0xDEADBEEF, and the same-cycle read returns the old value 0.
REQ-040 NumWritePorts=2: port 0 writes 0x11 to x7 and port 1 writes 0x22 to x7 in the same cycle -> x7 reads 0x22 the next cycle; then distinct addresses x3=0x33 and x4=0x44 are written together -> both are stored.
REQ-041 WriteForward=1: write 0xA5A5A5A5 to x9 while reading x9 in the same cycle -> returns 0xA5A5A5A5 immediately; a write to x0 with a read of x0 -> returns WordZeroVal.
REQ-042 DummyInstructions=1: write 0x1234 to x0 with dummy_instr_id_i=1 -> an x0 read with dummy=1 returns 0x1234, and with dummy=0 returns 0.
REQ-043 RV32E=1, WrenCheck=1: write with waddr=5'h13 -> x3 is updated, err_o=1 the next cycle and stays 1, then clears to 0 only on rst_ni=0.
REQ-044 Reset mid-operation: assert rst_ni=0 asynchronously between edges after writing x1=0xFF -> x1 reads WordResetVal immediately and err_o=0.
